// File: rtl/sha256_padder_if.sv
// Byte-in / block-out handshake bundle for the SHA-256 padder.
// master is the padder side, slave is the producer/consumer side.
interface sha256_padder_if;
    logic         i_valid;
    logic [7:0]   i_data;
    logic         i_last;
    logic         o_ready;
    logic         o_blk_valid;
    logic [511:0] o_blk_data;
    logic         o_blk_last;
    logic         i_blk_ready;

    modport master (
        input  i_valid, i_data, i_last, i_blk_ready,
        output o_ready, o_blk_valid, o_blk_data, o_blk_last
    );

    modport slave (
        output i_valid, i_data, i_last, i_blk_ready,
        input  o_ready, o_blk_valid, o_blk_data, o_blk_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs bytes into 512-bit blocks with 0x80/zero/length padding.
// Optional block counter output o_blk_cnt is enabled by macro SHA256_PADDER_BLKCNT_EN.
module sha256_padder #(
    parameter int LEN_W = 61
) (
    input  logic clk,
    input  logic rst,
`ifdef SHA256_PADDER_BLKCNT_EN
    output logic [15:0] o_blk_cnt,
`endif
    sha256_padder_if.master bus
);

    typedef enum logic [1:0] {
        FILL,
        SEND,
        PAD2,
        SEND_LAST
    } state_t;

    state_t           state;
    logic [5:0]       idx;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic             pad2;
    logic             marker;
    logic [511:0]     blk;
    logic [511:0]     fill_blk;
    logic [511:0]     pad_blk;
    logic [63:0]      len_inc;
    logic [63:0]      len_cur;
    logic             ready_r;
    logic             valid_r;
    logic             last_r;

    assign cnt_inc = cnt + 1'b1;
    assign len_inc = 64'({cnt_inc, 3'b000});
    assign len_cur = 64'({cnt, 3'b000});
    assign pad_blk = {(marker ? 8'h80 : 8'h00), 440'h0, len_cur};

    assign bus.o_ready     = ready_r;
    assign bus.o_blk_valid = valid_r;
    assign bus.o_blk_data  = blk;
    assign bus.o_blk_last  = last_r;

    // Byte j lives at [511-8j -: 8]; a last byte also lays down the padding tail.
    always_comb begin
        fill_blk = blk;
        for (int j = 0; j < 64; j++) begin
            if (j == int'(idx)) begin
                fill_blk[511-8*j -: 8] = bus.i_data;
            end else if (bus.i_last && j > int'(idx)) begin
                fill_blk[511-8*j -: 8] = (j == int'(idx) + 1) ? 8'h80 : 8'h00;
                if (idx <= 6'd54 && j >= 56)
                    fill_blk[511-8*j -: 8] = len_inc[63-8*(j-56) -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            idx     <= '0;
            cnt     <= '0;
            pad2    <= 1'b0;
            marker  <= 1'b0;
            blk     <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (bus.i_valid) begin
                        blk <= fill_blk;
                        idx <= idx + 1'b1;
                        cnt <= cnt_inc;
                        if (bus.i_last) begin
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                            if (idx <= 6'd54) begin
                                state  <= SEND_LAST;
                                last_r <= 1'b1;
                            end else begin
                                state  <= SEND;
                                last_r <= 1'b0;
                                pad2   <= 1'b1;
                                marker <= (idx == 6'd63);
                            end
                        end else if (idx == 6'd63) begin
                            state   <= SEND;
                            last_r  <= 1'b0;
                            ready_r <= 1'b0;
                            valid_r <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.i_blk_ready) begin
                        valid_r <= 1'b0;
                        if (pad2) begin
                            state <= PAD2;
                        end else begin
                            state   <= FILL;
                            idx     <= '0;
                            ready_r <= 1'b1;
                        end
                    end
                end
                PAD2: begin
                    blk     <= pad_blk;
                    pad2    <= 1'b0;
                    marker  <= 1'b0;
                    last_r  <= 1'b1;
                    valid_r <= 1'b1;
                    state   <= SEND_LAST;
                end
                SEND_LAST: begin
                    if (bus.i_blk_ready) begin
                        state   <= FILL;
                        idx     <= '0;
                        cnt     <= '0;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef SHA256_PADDER_BLKCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_blk_cnt <= '0;
        else if (valid_r && bus.i_blk_ready)
            o_blk_cnt <= o_blk_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages with hand-built expected blocks.
// A negedge monitor pops and compares every block handshake.
module tb_sha256_padder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_padder_if bus();

`ifdef SHA256_PADDER_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    sha256_padder #(.LEN_W(61)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SHA256_PADDER_BLKCNT_EN
        .o_blk_cnt(blk_cnt),
`endif
        .bus(bus)
    );

    typedef struct {
        logic [511:0] blk;
        logic         last;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  msg[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] put(input logic [511:0] b, input int i,
                                         input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[511-8*i -: 8] = v;
        return r;
    endfunction

    task automatic expect_blk(input logic [511:0] b, input logic l);
        exp_t e;
        e.blk  = b;
        e.last = l;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.o_blk_valid && bus.i_blk_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_block: got %0h expected none", bus.o_blk_data);
            end else begin
                e = sb.pop_front();
                check("blk_data", bus.o_blk_data, e.blk);
                check("blk_last", 512'(bus.o_blk_last), 512'(e.last));
            end
        end
    end

    // Sends msg[] back to back; returns at posedge+1 after the final byte is taken.
    task automatic send_msg();
        int t;
        for (int i = 0; i < msg.size(); i++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_data  = msg[i];
            bus.i_last  = (i == msg.size() - 1);
            t = 0;
            while (!bus.o_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_timeout: got o_ready=0 expected o_ready=1");
            end
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            bus.i_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [511:0] e1;
    logic [511:0] abc_blk;

    initial begin
        bus.i_valid     = 1'b0;
        bus.i_data      = 8'h00;
        bus.i_last      = 1'b0;
        bus.i_blk_ready = 1'b1;
        abc_blk = {32'h61626380, 416'h0, 64'h18};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 512'(bus.o_ready), 512'(1));
        check("rst_valid", 512'(bus.o_blk_valid), 512'(0));
        check("rst_last", 512'(bus.o_blk_last), 512'(0));
        check("rst_data", bus.o_blk_data, 512'h0);

        // "abc" and one-cycle latency
        msg = '{8'h61, 8'h62, 8'h63};
        expect_blk(abc_blk, 1'b1);
        send_msg();
        check("abc_latency", 512'(bus.o_blk_valid), 512'(1));
        drain();

        // single byte
        msg = '{8'h41};
        expect_blk({16'h4180, 432'h0, 64'h8}, 1'b1);
        send_msg();
        drain();

        // 55 zero bytes: last one-block case
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'h00);
        expect_blk({440'h0, 8'h80, 64'h1B8}, 1'b1);
        send_msg();
        drain();

        // 56 bytes: first two-block case
        msg.delete();
        e1 = '0;
        for (int i = 0; i < 56; i++) begin
            msg.push_back(8'(i + 1));
            e1 = put(e1, i, 8'(i + 1));
        end
        e1 = put(e1, 56, 8'h80);
        expect_blk(e1, 1'b0);
        expect_blk(512'h1C0, 1'b1);
        send_msg();
        drain();

        // 63 bytes: 0x80 lands in the final byte slot
        msg.delete();
        e1 = '0;
        for (int i = 0; i < 63; i++) begin
            msg.push_back(8'(i + 1));
            e1 = put(e1, i, 8'(i + 1));
        end
        e1 = put(e1, 63, 8'h80);
        expect_blk(e1, 1'b0);
        expect_blk(512'h1F8, 1'b1);
        send_msg();
        drain();

        // 64 bytes: marker moves 0x80 into the second block
        msg.delete();
        e1 = '0;
        for (int i = 0; i < 64; i++) begin
            msg.push_back(8'(i + 1));
            e1 = put(e1, i, 8'(i + 1));
        end
        expect_blk(e1, 1'b0);
        expect_blk({8'h80, 440'h0, 64'h200}, 1'b1);
        send_msg();
        drain();

        // back-pressure: hold i_blk_ready low for 10 cycles
        @(posedge clk);
        #1 bus.i_blk_ready = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        expect_blk(abc_blk, 1'b1);
        send_msg();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 512'(bus.o_blk_valid), 512'(1));
            check("stall_data", bus.o_blk_data, abc_blk);
            check("stall_ready", 512'(bus.o_ready), 512'(0));
        end
        @(posedge clk);
        #1 bus.i_blk_ready = 1'b1;
        drain();

        // reset mid-message discards the partial bytes
        msg.delete();
        for (int i = 0; i < 30; i++) msg.push_back(8'hA5);
        send_msg();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 512'(bus.o_ready), 512'(1));
        check("midrst_valid", 512'(bus.o_blk_valid), 512'(0));
        msg = '{8'h61, 8'h62, 8'h63};
        expect_blk(abc_blk, 1'b1);
        send_msg();
        drain();
`ifdef SHA256_PADDER_BLKCNT_EN
        check("blk_cnt", 512'(blk_cnt), 512'(1));
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 512'(sb.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
